// File: rtl/axis_frame_store.sv
// axis_frame_store: single-clock AXI-Stream store-and-forward frame buffer.
// Define FRAME_STORE_STATS_EN to add saturating frame in/drop counters.
module axis_frame_store #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_FRAMES = 16
) (
    input  logic                              axis_aclk,
    input  logic                              axis_areset,
    input  logic [DATA_WIDTH-1:0]             s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]           s01_axis_tstrb,
    input  logic                              s01_axis_tvalid,
    input  logic                              s01_axis_tlast,
    output logic                              s01_axis_tready,
    output logic [DATA_WIDTH-1:0]             m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m01_axis_tstrb,
    output logic                              m01_axis_tvalid,
    output logic                              m01_axis_tlast,
    input  logic                              m01_axis_tready,
    output logic [$clog2(MAX_FRAMES+1)-1:0]   frame_count,
`ifdef FRAME_STORE_STATS_EN
    output logic [31:0]                       stat_frames_in,
    output logic [31:0]                       stat_frames_dropped,
`endif
    output logic                              frame_drop
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(MAX_FRAMES + 1);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int PW         = ADDR_WIDTH + 1;
    localparam int EW         = DATA_WIDTH + STRB_WIDTH + 1;

    localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] MAX_C   = CNT_WIDTH'(MAX_FRAMES);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FRAME = 2'd1;
    localparam logic [1:0] W_DROP  = 2'd2;

    logic [1:0]           wstate_q, wstate_d;
    logic [PW-1:0]        wr_start_q, wr_start_d;
    logic [PW-1:0]        wr_cur_q, wr_cur_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                 en_q;

    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        rd_data_q;
    logic                 rd_vld_q;

    logic [EW-1:0]        ob_q [2];
    logic                 ob_head_q;
    logic [1:0]           ob_cnt_q;

    logic                 full;
    logic                 s_hs;
    logic                 wr_en;
    logic                 commit;
    logic                 drop;
    logic                 pop;
    logic                 avail;
    logic                 issue;
    logic                 ob_wr_idx;
    logic [2:0]           occ;

    assign full = (wr_cur_q - rd_ptr_q) == DEPTH_P;
    assign s_hs = s01_axis_tvalid && s01_axis_tready;

    always_comb begin
        s01_axis_tready = 1'b0;
        unique case (wstate_q)
            W_IDLE:  s01_axis_tready = en_q && !full && (fcnt_q < MAX_C);
            W_FRAME: s01_axis_tready = 1'b1;
            W_DROP:  s01_axis_tready = 1'b1;
            default: s01_axis_tready = 1'b0;
        endcase
    end

    // Write FSM: the writer is never stalled once a frame has started.
    always_comb begin
        wstate_d   = wstate_q;
        wr_start_d = wr_start_q;
        wr_cur_d   = wr_cur_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (s_hs) begin
                    wr_en    = 1'b1;
                    wr_cur_d = wr_cur_q + PW'(1);
                    if (s01_axis_tlast) begin
                        commit     = 1'b1;
                        wr_start_d = wr_cur_q + PW'(1);
                    end else begin
                        wstate_d = W_FRAME;
                    end
                end
            end
            W_FRAME: begin
                if (s_hs) begin
                    if (full) begin
                        drop     = 1'b1;
                        wr_cur_d = wr_start_q;
                        wstate_d = s01_axis_tlast ? W_IDLE : W_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_cur_d = wr_cur_q + PW'(1);
                        if (s01_axis_tlast) begin
                            commit     = 1'b1;
                            wr_start_d = wr_cur_q + PW'(1);
                            wstate_d   = W_IDLE;
                        end
                    end
                end
            end
            W_DROP: begin
                if (s_hs && s01_axis_tlast) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign frame_drop = drop;

    // Read credit counts output entries plus the beat in flight from RAM.
    assign pop       = m01_axis_tvalid && m01_axis_tready;
    assign avail     = rd_ptr_q != wr_start_q;
    assign occ       = {1'b0, ob_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign issue     = avail && (occ < 3'd2);
    assign ob_wr_idx = ob_head_q ^ ob_cnt_q[0];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (commit && !(pop && m01_axis_tlast)) begin
            fcnt_d = fcnt_q + CNT_WIDTH'(1);
        end else if (!commit && pop && m01_axis_tlast) begin
            fcnt_d = fcnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_cur_q[ADDR_WIDTH-1:0]] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
        end
        if (issue) begin
            rd_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            wstate_q   <= W_IDLE;
            wr_start_q <= '0;
            wr_cur_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            en_q       <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wr_start_q <= wr_start_d;
            wr_cur_q   <= wr_cur_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            en_q       <= 1'b1;
            rd_vld_q   <= issue;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            ob_q[0]   <= '0;
            ob_q[1]   <= '0;
            ob_head_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
        end else begin
            if (rd_vld_q) begin
                ob_q[ob_wr_idx] <= rd_data_q;
            end
            if (pop) begin
                ob_head_q <= ~ob_head_q;
            end
            ob_cnt_q <= ob_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        end
    end

    assign m01_axis_tvalid = ob_cnt_q != 2'd0;
    assign {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata} = ob_q[ob_head_q];
    assign frame_count = fcnt_q;

`ifdef FRAME_STORE_STATS_EN
    logic [31:0] stat_in_q;
    logic [31:0] stat_drop_q;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            stat_in_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            if (commit && stat_in_q != 32'hFFFF_FFFF) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (drop && stat_drop_q != 32'hFFFF_FFFF) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
        end
    end

    assign stat_frames_in      = stat_in_q;
    assign stat_frames_dropped = stat_drop_q;
`endif

endmodule

// File: tb/tb_axis_frame_store.sv
// Scoreboard bench for axis_frame_store: a default-size instance and a
// DEPTH=8 instance share stimulus, selected by sel.
module tb_axis_frame_store;

    typedef struct packed {
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b0;

    logic        b_s_tready, l_s_tready;
    logic [31:0] b_m_tdata, l_m_tdata;
    logic [3:0]  b_m_tstrb, l_m_tstrb;
    logic        b_m_tvalid, l_m_tvalid;
    logic        b_m_tlast, l_m_tlast;
    logic [4:0]  b_fc;
    logic [3:0]  l_fc;
    logic        b_drop, l_drop;

    logic        s_tready, m_tvalid, m_tlast, frame_drop;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [4:0]  fc;

`ifdef FRAME_STORE_STATS_EN
    logic [31:0] b_stat_in, b_stat_drop, l_stat_in, l_stat_drop;
`endif

    int checks = 0;
    int errors = 0;
    int drop_seen = 0;
    int vld_seen = 0;
    logic hs_drop = 1'b0;
    beat_t sb[$];

    always #5 clk = ~clk;

    assign s_tready   = sel ? l_s_tready : b_s_tready;
    assign m_tvalid   = sel ? l_m_tvalid : b_m_tvalid;
    assign m_tlast    = sel ? l_m_tlast : b_m_tlast;
    assign m_tdata    = sel ? l_m_tdata : b_m_tdata;
    assign m_tstrb    = sel ? l_m_tstrb : b_m_tstrb;
    assign fc         = sel ? {1'b0, l_fc} : b_fc;
    assign frame_drop = sel ? l_drop : b_drop;

    axis_frame_store dut (
        .axis_aclk          (clk),
        .axis_areset        (rst),
        .s01_axis_tdata     (s_tdata),
        .s01_axis_tstrb     (s_tstrb),
        .s01_axis_tvalid    (s_tvalid & ~sel),
        .s01_axis_tlast     (s_tlast),
        .s01_axis_tready    (b_s_tready),
        .m01_axis_tdata     (b_m_tdata),
        .m01_axis_tstrb     (b_m_tstrb),
        .m01_axis_tvalid    (b_m_tvalid),
        .m01_axis_tlast     (b_m_tlast),
        .m01_axis_tready    (m_tready & ~sel),
        .frame_count        (b_fc),
`ifdef FRAME_STORE_STATS_EN
        .stat_frames_in     (b_stat_in),
        .stat_frames_dropped(b_stat_drop),
`endif
        .frame_drop         (b_drop)
    );

    axis_frame_store #(.ADDR_WIDTH(3), .MAX_FRAMES(8)) dut_small (
        .axis_aclk          (clk),
        .axis_areset        (rst),
        .s01_axis_tdata     (s_tdata),
        .s01_axis_tstrb     (s_tstrb),
        .s01_axis_tvalid    (s_tvalid & sel),
        .s01_axis_tlast     (s_tlast),
        .s01_axis_tready    (l_s_tready),
        .m01_axis_tdata     (l_m_tdata),
        .m01_axis_tstrb     (l_m_tstrb),
        .m01_axis_tvalid    (l_m_tvalid),
        .m01_axis_tlast     (l_m_tlast),
        .m01_axis_tready    (m_tready & sel),
        .frame_count        (l_fc),
`ifdef FRAME_STORE_STATS_EN
        .stat_frames_in     (l_stat_in),
        .stat_frames_dropped(l_stat_drop),
`endif
        .frame_drop         (l_drop)
    );

    always @(negedge clk) begin
        if (frame_drop) drop_seen++;
        if (m_tvalid) vld_seen++;
    end

    // Entry and exit point: just after a rising edge.
    task automatic drive_beat(input beat_t b, input int gap_pct, input bit push);
        int w = 0;
        while ($urandom_range(99) < gap_pct) begin
            @(posedge clk); #1;
        end
        s_tdata  = b.data;
        s_tstrb  = b.strb;
        s_tlast  = b.last;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!s_tready) begin
            errors++;
            $display("FAIL s_handshake_timeout: tready=%0b required 1", s_tready);
        end
        hs_drop = frame_drop;
        if (push) sb.push_back(b);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic consume(input int nbeats, input int rdy_pct);
        int got = 0;
        int waited = 0;
        logic stalled = 1'b0;
        beat_t held = '0;
        beat_t cur;
        beat_t exp;
        while (got < nbeats && waited < nbeats * 40 + 300) begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            waited++;
            cur = {m_tlast, m_tstrb, m_tdata};
            if (stalled) begin
                checks++;
                if (!m_tvalid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b beat=%h required held %h", m_tvalid, cur, held);
                end
            end
            if (m_tvalid && m_tready) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h with empty scoreboard", cur);
                end else begin
                    exp = sb.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL beat_data: got %h required %h", cur, exp);
                    end
                end
            end
            stalled = m_tvalid && !m_tready;
            held = cur;
        end
        checks++;
        if (got != nbeats) begin
            errors++;
            $display("FAIL consume_timeout: got %0d beats required %0d", got, nbeats);
        end
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({b_s_tready, b_m_tvalid, b_m_tlast, b_m_tstrb, b_m_tdata, b_fc, b_drop} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_big: tready=%0b tvalid=%0b fc=%0d required all 0",
                     b_s_tready, b_m_tvalid, b_fc);
        end
        checks++;
        if ({l_s_tready, l_m_tvalid, l_m_tlast, l_m_tstrb, l_m_tdata, l_fc, l_drop} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_small: tready=%0b tvalid=%0b fc=%0d required all 0",
                     l_s_tready, l_m_tvalid, l_fc);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (b_s_tready !== 1'b1 || l_s_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %0b/%0b required 1/1", b_s_tready, l_s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        beat_t b;
        sel = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (fc !== 5'd0) begin
            errors++;
            $display("FAIL t1_fc_start: got %0d required 0", fc);
        end
        for (int i = 0; i < 3; i++) begin
            b.data = 32'h11 * (i + 1);
            b.strb = 4'hF;
            b.last = (i == 2);
            drive_beat(b, 0, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (fc !== 5'd1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL t1_commit: fc=%0d tvalid=%0b required 1/0", fc, m_tvalid);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency_early: tvalid=%0b required 0", m_tvalid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b = sb.pop_front();
            checks++;
            if (m_tvalid !== 1'b1 || {m_tlast, m_tstrb, m_tdata} !== b) begin
                errors++;
                $display("FAIL t1_beat%0d: valid=%0b beat=%h required 1 %h",
                         k, m_tvalid, {m_tlast, m_tstrb, m_tdata}, b);
            end
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || fc !== 5'd0) begin
            errors++;
            $display("FAIL t1_end: tvalid=%0b fc=%0d required 0/0", m_tvalid, fc);
        end
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    task automatic test_frame_limit;
        beat_t b;
        sel = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b.data = 32'h100 + i;
            b.strb = 4'(i + 1);
            b.last = 1'b1;
            drive_beat(b, 0, 1'b1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (fc !== 5'd16 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL t2_limit: fc=%0d tready=%0b required 16/0", fc, s_tready);
        end
        @(posedge clk); #1;
        consume(16, 100);
        @(negedge clk);
        checks++;
        if (fc !== 5'd0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL t2_drain: fc=%0d tready=%0b required 0/1", fc, s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drop;
        beat_t b;
        int d0, v0, drop_at;
        sel = 1'b1;
        m_tready = 1'b1;
        d0 = drop_seen;
        v0 = vld_seen;
        drop_at = 0;
        for (int i = 0; i < 10; i++) begin
            b.data = 32'hD00 + i;
            b.strb = 4'hF;
            b.last = (i == 9);
            drive_beat(b, 0, 1'b0);
            if (hs_drop) drop_at = i + 1;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (drop_seen - d0 != 1 || drop_at != 9) begin
            errors++;
            $display("FAIL t3_drop: pulses=%0d beat=%0d required 1 on beat 9", drop_seen - d0, drop_at);
        end
        checks++;
        if (vld_seen != v0 || fc !== 5'd0) begin
            errors++;
            $display("FAIL t3_no_output: valid_cycles=%0d fc=%0d required 0/0", vld_seen - v0, fc);
        end
        for (int i = 0; i < 2; i++) begin
            b.data = 32'hE00 + i;
            b.strb = 4'(3 + i);
            b.last = (i == 1);
            drive_beat(b, 0, 1'b1);
        end
        consume(2, 100);
        @(negedge clk);
        checks++;
        if (fc !== 5'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL t3_after: fc=%0d pending=%0d required 0/0", fc, sb.size());
        end
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic test_random_stress;
        int lens[200];
        int total = 0;
        beat_t b;
        sel = 1'b0;
        for (int f = 0; f < 200; f++) begin
            lens[f] = $urandom_range(6, 1);
            total += lens[f];
        end
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    for (int k = 0; k < lens[f]; k++) begin
                        b.data = $urandom;
                        b.strb = 4'($urandom_range(15));
                        b.last = (k == lens[f] - 1);
                        drive_beat(b, 30, 1'b1);
                    end
                end
            end
            consume(total, 60);
        join
        @(negedge clk);
        checks++;
        if (fc !== 5'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL t4_end: fc=%0d pending=%0d required 0/0", fc, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        beat_t b;
        sel = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b.data = 32'hA00 + i;
            b.strb = 4'hF;
            b.last = (i == 1);
            drive_beat(b, 0, 1'b0);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tstrb, m_tdata, s_tready, fc, frame_drop} !== '0) begin
            errors++;
            $display("FAIL t5_async: tvalid=%0b data=%h tready=%0b fc=%0d required all 0",
                     m_tvalid, m_tdata, s_tready, fc);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (fc !== 5'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL t5_release: fc=%0d tvalid=%0b tready=%0b required 0/0/1", fc, m_tvalid, s_tready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            b.data = 32'hB00 + i;
            b.strb = 4'(i + 5);
            b.last = (i == 2);
            drive_beat(b, 0, 1'b1);
        end
        consume(3, 100);
        @(negedge clk);
        checks++;
        if (fc !== 5'd0) begin
            errors++;
            $display("FAIL t5_new_frame: fc=%0d required 0", fc);
        end
        @(posedge clk); #1;
    endtask

`ifdef FRAME_STORE_STATS_EN
    task automatic test_stats;
        do_reset();
        test_drop();
        @(negedge clk);
        checks++;
        if (l_stat_in !== 32'd1 || l_stat_drop !== 32'd1) begin
            errors++;
            $display("FAIL t6_stats: in=%0d dropped=%0d required 1/1", l_stat_in, l_stat_drop);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_single_frame();
        test_frame_limit();
        test_drop();
        test_random_stress();
        test_mid_reset();
`ifdef FRAME_STORE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
